// File: rtl/cargador_operandos.sv
// ---------------------------------------------------------------------------
// cargador_operandos
//
// Purpose: collects two operands from a single data input (switches) into
// registered outputs a and b, which feed a subtractor. A three-state FSM
// (ESPERA_A -> ESPERA_B -> LISTO) tracks which operand is loaded next. A
// downstream acknowledge (tomar) consumes the complete pair and increments a
// wrapping counter of consumed pairs.
//
// Configuration macro: CARGADOR_OPERANDOS_FLANCO_EN
//   defined   : cargar is a level input; only its rising edge is a load.
//   undefined : every cycle with cargar=1 is a load (one-cycle strobes).
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   dato        in   [ANCHO-1:0]     operand value, sampled on a load
//   cargar      in   load request
//   tomar       in   downstream acknowledge, consumes the pair in LISTO
//   a           out  [ANCHO-1:0]     first operand
//   b           out  [ANCHO-1:0]     second operand
//   validos     out  high while a/b hold a complete, unconsumed pair
//   esperando_b out  high while waiting for the second operand
//   descartado  out  sticky: a load was lost while the pair was full
//   n_ops       out  [ANCHO_CNT-1:0] consumed pair count (wraps)
// ---------------------------------------------------------------------------
module cargador_operandos #(
  parameter int ANCHO     = 3,
  parameter int ANCHO_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO-1:0]     dato,
  input  logic                 cargar,
  input  logic                 tomar,
  output logic [ANCHO-1:0]     a,
  output logic [ANCHO-1:0]     b,
  output logic                 validos,
  output logic                 esperando_b,
  output logic                 descartado,
  output logic [ANCHO_CNT-1:0] n_ops
);

  typedef enum logic [1:0] {
    ESPERA_A = 2'b00,
    ESPERA_B = 2'b01,
    LISTO    = 2'b10
  } estado_t;

  estado_t              state_reg, state_next;
  logic [ANCHO-1:0]     a_reg, a_next;
  logic [ANCHO-1:0]     b_reg, b_next;
  logic [ANCHO_CNT-1:0] n_ops_reg, n_ops_next;
  logic                 descartado_reg, descartado_next;
  logic                 carga;

`ifdef CARGADOR_OPERANDOS_FLANCO_EN
  // Previous value of cargar; a load is the 0->1 transition, so a held
  // button produces exactly one load.
  logic cargar_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cargar_prev_reg <= 1'b0;
    end else begin
      cargar_prev_reg <= cargar;
    end
  end

  assign carga = cargar & ~cargar_prev_reg;
`else
  assign carga = cargar;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ESPERA_A;
      a_reg          <= '0;
      b_reg          <= '0;
      n_ops_reg      <= '0;
      descartado_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      n_ops_reg      <= n_ops_next;
      descartado_reg <= descartado_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    n_ops_next      = n_ops_reg;
    descartado_next = descartado_reg;

    case (state_reg)
      ESPERA_A: begin
        if (carga) begin
          a_next     = dato;
          state_next = ESPERA_B;
        end
      end

      ESPERA_B: begin
        if (carga) begin
          b_next     = dato;
          state_next = LISTO;
        end
      end

      LISTO: begin
        if (tomar) begin
          n_ops_next = n_ops_reg + ANCHO_CNT'(1);
          // A load arriving together with the acknowledge starts the next
          // pair immediately instead of being lost.
          if (carga) begin
            a_next     = dato;
            state_next = ESPERA_B;
          end else begin
            state_next = ESPERA_A;
          end
        end else if (carga) begin
          descartado_next = 1'b1;
        end
      end

      default: begin
        // Unused encoding: recover to a clean start.
        state_next = ESPERA_A;
      end
    endcase
  end

  assign a           = a_reg;
  assign b           = b_reg;
  assign n_ops       = n_ops_reg;
  assign descartado  = descartado_reg;
  assign validos     = (state_reg == LISTO);
  assign esperando_b = (state_reg == ESPERA_B);

endmodule

// File: tb/tb_cargador_operandos.sv
// ---------------------------------------------------------------------------
// tb_cargador_operandos
//
// Self-checking bench for cargador_operandos (default parameters). A
// behavioural model tracks how many operands are held (0, 1 or 2), the
// operand values, the consumed-pair count and the lost-load flag; every
// clock step compares all outputs with it. Directed scenarios are followed
// by a randomized run. Works with or without CARGADOR_OPERANDOS_FLANCO_EN.
// ---------------------------------------------------------------------------
module tb_cargador_operandos;

  logic       clk;
  logic       rst;
  logic [2:0] dato;
  logic       cargar;
  logic       tomar;
  logic [2:0] a;
  logic [2:0] b;
  logic       validos;
  logic       esperando_b;
  logic       descartado;
  logic [3:0] n_ops;

  cargador_operandos #(.ANCHO(3), .ANCHO_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .dato        (dato),
    .cargar      (cargar),
    .tomar       (tomar),
    .a           (a),
    .b           (b),
    .validos     (validos),
    .esperando_b (esperando_b),
    .descartado  (descartado),
    .n_ops       (n_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference model state
  int         m_held;   // operands currently held: 0, 1 or 2
  logic [2:0] m_a;
  logic [2:0] m_b;
  int         m_n;
  logic       m_desc;
  logic       m_prev;   // last sampled cargar, for edge-mode loads

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, obs, exp, n_step);
    end
  endtask

  // Apply one clock cycle of stimulus, advance the model, compare outputs.
  task automatic step(input logic r, input logic c, input logic t, input logic [2:0] d);
    bit ld;
    rst = r; cargar = c; tomar = t; dato = d;
    @(posedge clk);
    n_step++;
    if (r) begin
      m_held = 0; m_a = 3'd0; m_b = 3'd0; m_n = 0; m_desc = 1'b0; m_prev = 1'b0;
    end else begin
`ifdef CARGADOR_OPERANDOS_FLANCO_EN
      ld = c && !m_prev;
`else
      ld = c;
`endif
      m_prev = c;
      if (m_held == 0) begin
        if (ld) begin m_a = d; m_held = 1; end
      end else if (m_held == 1) begin
        if (ld) begin m_b = d; m_held = 2; end
      end else begin
        if (t) begin
          m_n = (m_n + 1) % 16;
          if (ld) begin m_a = d; m_held = 1; end
          else m_held = 0;
        end else if (ld) begin
          m_desc = 1'b1;
        end
      end
    end
    #1;
    $display("step %0d rst=%0b cargar=%0b tomar=%0b dato=%0d -> a=%0d b=%0d validos=%0b esperando_b=%0b descartado=%0b n_ops=%0d",
             n_step, r, c, t, d, a, b, validos, esperando_b, descartado, n_ops);
    chk("a", 32'(a), 32'(m_a));
    chk("b", 32'(b), 32'(m_b));
    chk("validos", 32'(validos), 32'(m_held == 2));
    chk("esperando_b", 32'(esperando_b), 32'(m_held == 1));
    chk("descartado", 32'(descartado), 32'(m_desc));
    chk("n_ops", 32'(n_ops), 32'(m_n));
  endtask

  // One load: strobe then an idle cycle so edge mode also sees each load.
  task automatic cargar_op(input logic [2:0] d);
    step(1'b0, 1'b1, 1'b0, d);
    step(1'b0, 1'b0, 1'b0, d);
  endtask

  logic [2:0] diff;

  initial begin
    rst = 1'b1; cargar = 1'b0; tomar = 1'b0; dato = 3'd0;
    m_held = 0; m_a = 3'd0; m_b = 3'd0; m_n = 0; m_desc = 1'b0; m_prev = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 3'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_validos", 32'(validos), 32'd0);
    chk("rst_n_ops", 32'(n_ops), 32'd0);

    // Scenario 1: load 101 then 100
    cargar_op(3'b101);
    step(1'b0, 1'b1, 1'b0, 3'b100);
    chk("s1_validos", 32'(validos), 32'd1);
    chk("s1_a", 32'(a), 32'd5);
    chk("s1_b", 32'(b), 32'd4);
    diff = a - b;
    chk("s1_res", 32'(diff), 32'd1);
    step(1'b0, 1'b0, 1'b0, 3'd0);

    // Scenario 2: load while full and no tomar -> lost, sticky flag
    step(1'b0, 1'b1, 1'b0, 3'b011);
    chk("s2_desc", 32'(descartado), 32'd1);
    chk("s2_a", 32'(a), 32'd5);
    chk("s2_b", 32'(b), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'd0);
    chk("s2_desc_sticky", 32'(descartado), 32'd1);
    step(1'b0, 1'b0, 1'b1, 3'd0);
    chk("s2_desc_after_tomar", 32'(descartado), 32'd1);

    // Scenario 3: tomar and load in the same cycle
    step(1'b1, 1'b0, 1'b0, 3'd0);
    cargar_op(3'd2);
    cargar_op(3'd1);
    step(1'b0, 1'b1, 1'b1, 3'b110);
    chk("s3_n_ops", 32'(n_ops), 32'd1);
    chk("s3_a", 32'(a), 32'd6);
    chk("s3_esperando_b", 32'(esperando_b), 32'd1);
    chk("s3_validos", 32'(validos), 32'd0);
    chk("s3_desc", 32'(descartado), 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0);

    // Scenario 4: 16 full cycles, counter wraps to 0
    step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 16; i++) begin
      cargar_op(3'($urandom_range(0, 7)));
      cargar_op(3'($urandom_range(0, 7)));
      step(1'b0, 1'b0, 1'b1, 3'd0);
      chk("s4_n_ops", 32'(n_ops), 32'((i + 1) % 16));
    end
    // tomar ignored outside LISTO
    step(1'b0, 1'b0, 1'b1, 3'd0);
    chk("s4_tomar_idle", 32'(n_ops), 32'd0);

    // Scenario 5: reset with a load while in ESPERA_B
    step(1'b1, 1'b0, 1'b0, 3'd0);
    cargar_op(3'd5);
    step(1'b1, 1'b1, 1'b0, 3'd2);
    chk("s5_a", 32'(a), 32'd0);
    chk("s5_b", 32'(b), 32'd0);
    chk("s5_esperando_b", 32'(esperando_b), 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0);

    // Scenario 6: cargar held high for 5 cycles
    step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 3'd3);
`ifdef CARGADOR_OPERANDOS_FLANCO_EN
    chk("s6_esperando_b", 32'(esperando_b), 32'd1);
    chk("s6_desc", 32'(descartado), 32'd0);
`else
    chk("s6_validos", 32'(validos), 32'd1);
    chk("s6_desc", 32'(descartado), 32'd1);
`endif
    chk("s6_a", 32'(a), 32'd3);
    step(1'b0, 1'b0, 1'b0, 3'd0);

    // Randomized run against the model
    step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
